// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops narrow words, captures each one cycle after the pop and packs
// PACK_RATIO of them (first = LSBs) into a registered wide word; read enable drops while the output stalls.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_RATIO = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                             Clk,
  input  logic                             Reset_n_in,
  input  logic                             Fifo_Empty_in,
  input  logic [DATA_WIDTH-1:0]            Fifo_Data_in,
  output logic                             Fifo_ReadEn_out,
  input  logic                             Flush_in,
  output logic                             Out_Valid_out,
  input  logic                             Out_Ready_in,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] Out_Data_out,
  output logic [CNT_WIDTH-1:0]             Out_Count_out,
  output logic                             Busy_out
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(PACK_RATIO);

  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]                  fill;
  logic [CNT_WIDTH-1:0]                  eff;
  logic                                  rd_pend;
  logic                                  flush_pend;
  logic                                  out_free;
  logic                                  xfer;
  logic                                  flush_clr;
  logic                                  pop;
  logic [CNT_WIDTH:0]                    committed;
  logic [DATA_WIDTH*PACK_RATIO-1:0]      xfer_dat;

  always_comb begin
    out_free  = ~Out_Valid_out | Out_Ready_in;
    xfer      = out_free & ((fill == FULL) | (flush_pend & ~rd_pend & (fill != '0)));
    eff       = xfer ? '0 : fill;
    // Slots already filled plus the word still in flight must leave room for one more pop
    committed = {1'b0, eff} + {{CNT_WIDTH{1'b0}}, rd_pend};
    Fifo_ReadEn_out = Reset_n_in & ~Fifo_Empty_in & ~flush_pend & (committed < {1'b0, FULL});
    pop       = Fifo_ReadEn_out & ~Fifo_Empty_in;
    flush_clr = flush_pend & (xfer | ((fill == '0) & ~rd_pend));
    Busy_out  = (fill != '0) | rd_pend | Out_Valid_out | flush_pend;
  end

  // Slots beyond the fill level are zeroed so a partial word never carries stale data
  always_comb begin
    xfer_dat = '0;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (CNT_WIDTH'(k) < fill) xfer_dat[k*DATA_WIDTH +: DATA_WIDTH] = acc[k];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      acc           <= '0;
      fill          <= '0;
      rd_pend       <= 1'b0;
      flush_pend    <= 1'b0;
      Out_Valid_out <= 1'b0;
      Out_Data_out  <= '0;
      Out_Count_out <= '0;
    end else begin
      rd_pend <= pop;
      fill    <= eff + CNT_WIDTH'(rd_pend);
      for (int k = 0; k < PACK_RATIO; k++) begin
        if (rd_pend && (eff == CNT_WIDTH'(k))) acc[k] <= Fifo_Data_in;
      end
      if (flush_pend) flush_pend <= ~flush_clr;
      else            flush_pend <= Flush_in;
      if (xfer) begin
        Out_Valid_out <= 1'b1;
        Out_Data_out  <= xfer_dat;
        Out_Count_out <= fill;
      end else if (Out_Ready_in) begin
        Out_Valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO read port and an output scoreboard.
module tb_fifo_rd_packer;
  localparam int DW = 4;
  localparam int PR = 4;
  localparam int CW = 3;

  logic           Clk = 1'b0;
  logic           Reset_n_in = 1'b0;
  logic           Fifo_Empty_in = 1'b1;
  logic [DW-1:0]  Fifo_Data_in = 4'hF;
  logic           Fifo_ReadEn_out;
  logic           Flush_in = 1'b0;
  logic           Out_Valid_out;
  logic           Out_Ready_in = 1'b0;
  logic [DW*PR-1:0] Out_Data_out;
  logic [CW-1:0]  Out_Count_out;
  logic           Busy_out;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0]    q[$];
  logic [DW*PR-1:0] outq_d[$];
  logic [CW-1:0]    outq_c[$];
  int  pops = 0;
  int  ren_while_empty = 0;
  bit  empty_toggle = 1'b0;
  bit  phase = 1'b0;
  bit  pend_vld = 1'b0;
  logic [DW-1:0] pend_dat = '0;

  always #5 Clk = ~Clk;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset_n_in(Reset_n_in), .Fifo_Empty_in(Fifo_Empty_in), .Fifo_Data_in(Fifo_Data_in),
    .Fifo_ReadEn_out(Fifo_ReadEn_out), .Flush_in(Flush_in), .Out_Valid_out(Out_Valid_out),
    .Out_Ready_in(Out_Ready_in), .Out_Data_out(Out_Data_out), .Out_Count_out(Out_Count_out),
    .Busy_out(Busy_out)
  );

  // FIFO read-port model: popped word appears on the data bus for the following posedge; idle data is 4'hF
  always @(negedge Clk) begin
    Fifo_Data_in  = pend_vld ? pend_dat : 4'hF;
    phase         = ~phase;
    Fifo_Empty_in = (q.size() == 0) || (empty_toggle && phase);
    #1;
    pend_vld = 1'b0;
    if (Fifo_ReadEn_out && Fifo_Empty_in) ren_while_empty++;
    if (Fifo_ReadEn_out && !Fifo_Empty_in && q.size() > 0) begin
      pend_dat = q.pop_front();
      pend_vld = 1'b1;
      pops++;
    end
    if (Out_Valid_out && Out_Ready_in) begin
      outq_d.push_back(Out_Data_out);
      outq_c.push_back(Out_Count_out);
    end
  end

  task automatic tick();
    @(negedge Clk);
    #2;
  endtask

  task automatic load(input int first, input int last);
    for (int v = first; v <= last; v++) q.push_back(DW'(v));
  endtask

  function automatic logic [DW*PR-1:0] got_d(input int i);
    return (outq_d.size() > i) ? outq_d[i] : 'x;
  endfunction

  function automatic logic [CW-1:0] got_c(input int i);
    return (outq_c.size() > i) ? outq_c[i] : 'x;
  endfunction

  task automatic wait_outs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (outq_d.size() >= n) ok = 1'b1;
      else tick();
    end
    if (outq_d.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (!Busy_out) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    load(1, 8);
    tick(); tick();
    checks++; if (Fifo_ReadEn_out !== 1'b0) $display("FAIL reset_ren got %b exp 0", Fifo_ReadEn_out); else passes++;
    checks++; if (Out_Valid_out !== 1'b0) $display("FAIL reset_vld got %b exp 0", Out_Valid_out); else passes++;
    checks++; if (Busy_out !== 1'b0) $display("FAIL reset_busy got %b exp 0", Busy_out); else passes++;
    checks++; if (Out_Data_out !== 16'h0) $display("FAIL reset_dat got %h exp 0000", Out_Data_out); else passes++;
    checks++; if (Out_Count_out !== 3'd0) $display("FAIL reset_cnt got %0d exp 0", Out_Count_out); else passes++;
    @(negedge Clk);
    pops = 0;
    Out_Ready_in = 1'b1;
    Reset_n_in = 1'b1;
    #2;
    checks++; if (Fifo_ReadEn_out !== 1'b1) $display("FAIL first_pop_ren got %b exp 1", Fifo_ReadEn_out); else passes++;
  endtask

  task automatic test_stream();
    logic [7:0] ren;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      tick();
      ren[i] = Fifo_ReadEn_out;
    end
    checks++; if (ren !== 8'hF7) $display("FAIL stream_ren_pattern got %b exp 11110111", ren); else passes++;
    wait_outs(2, 20, ok);
    checks++; if (!ok) $display("FAIL stream_timeout got %0d words exp 2", outq_d.size()); else passes++;
    checks++; if (got_d(0) !== 16'h4321) $display("FAIL stream_w0 got %h exp 4321", got_d(0)); else passes++;
    checks++; if (got_c(0) !== 3'd4) $display("FAIL stream_c0 got %0d exp 4", got_c(0)); else passes++;
    checks++; if (got_d(1) !== 16'h8765) $display("FAIL stream_w1 got %h exp 8765", got_d(1)); else passes++;
    checks++; if (got_c(1) !== 3'd4) $display("FAIL stream_c1 got %0d exp 4", got_c(1)); else passes++;
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL stream_idle busy=%b exp 0", Busy_out); else passes++;
    checks++; if (outq_d.size() !== 2) $display("FAIL stream_count got %0d exp 2", outq_d.size()); else passes++;
  endtask

  task automatic test_backpressure();
    bit ok;
    @(negedge Clk);
    Out_Ready_in = 1'b0;
    outq_d.delete(); outq_c.delete();
    pops = 0;
    load(1, 12);
    for (int i = 0; i < 20 && !Out_Valid_out; i++) tick();
    checks++; if (Out_Data_out !== 16'h4321) $display("FAIL bp_first got %h exp 4321", Out_Data_out); else passes++;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (Out_Data_out !== 16'h4321) $display("FAIL bp_hold got %h exp 4321", Out_Data_out); else passes++;
    checks++; if (Out_Count_out !== 3'd4) $display("FAIL bp_cnt got %0d exp 4", Out_Count_out); else passes++;
    checks++; if (Out_Valid_out !== 1'b1) $display("FAIL bp_vld got %b exp 1", Out_Valid_out); else passes++;
    checks++; if (Fifo_ReadEn_out !== 1'b0) $display("FAIL bp_ren got %b exp 0", Fifo_ReadEn_out); else passes++;
    checks++; if (pops !== 8) $display("FAIL bp_pops got %0d exp 8", pops); else passes++;
    @(negedge Clk);
    Out_Ready_in = 1'b1;
    wait_outs(3, 40, ok);
    checks++; if (!ok) $display("FAIL bp_timeout got %0d words exp 3", outq_d.size()); else passes++;
    checks++; if (got_d(0) !== 16'h4321) $display("FAIL bp_w0 got %h exp 4321", got_d(0)); else passes++;
    checks++; if (got_d(1) !== 16'h8765) $display("FAIL bp_w1 got %h exp 8765", got_d(1)); else passes++;
    checks++; if (got_d(2) !== 16'hCBA9) $display("FAIL bp_w2 got %h exp cba9", got_d(2)); else passes++;
    wait_idle(ok);
    checks++; if (outq_d.size() !== 3) $display("FAIL bp_no_dup got %0d exp 3", outq_d.size()); else passes++;
  endtask

  task automatic test_flush();
    bit ok;
    outq_d.delete(); outq_c.delete();
    pops = 0;
    load(10, 12);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (pops !== 3) $display("FAIL flush_pops got %0d exp 3", pops); else passes++;
    checks++; if (Out_Valid_out !== 1'b0) $display("FAIL flush_early_vld got %b exp 0", Out_Valid_out); else passes++;
    checks++; if (Busy_out !== 1'b1) $display("FAIL flush_busy_partial got %b exp 1", Busy_out); else passes++;
    @(negedge Clk); Flush_in = 1'b1;
    @(negedge Clk); Flush_in = 1'b0;
    wait_outs(1, 10, ok);
    checks++; if (got_d(0) !== 16'h0CBA) $display("FAIL flush_word got %h exp 0cba", got_d(0)); else passes++;
    checks++; if (got_c(0) !== 3'd3) $display("FAIL flush_cnt got %0d exp 3", got_c(0)); else passes++;
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL flush_idle busy=%b exp 0", Busy_out); else passes++;
    @(negedge Clk); Flush_in = 1'b1;
    @(negedge Clk); Flush_in = 1'b0;
    #2;
    checks++; if (Busy_out !== 1'b1) $display("FAIL flush_empty_pend got %b exp 1", Busy_out); else passes++;
    tick();
    checks++; if (Busy_out !== 1'b0) $display("FAIL flush_empty_clear got %b exp 0", Busy_out); else passes++;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (outq_d.size() !== 1) $display("FAIL flush_empty_noout got %0d words exp 1", outq_d.size()); else passes++;
  endtask

  task automatic test_empty_toggle();
    bit ok;
    outq_d.delete(); outq_c.delete();
    pops = 0;
    ren_while_empty = 0;
    empty_toggle = 1'b1;
    load(1, 8);
    wait_outs(2, 60, ok);
    checks++; if (!ok) $display("FAIL tog_timeout got %0d words exp 2", outq_d.size()); else passes++;
    checks++; if (got_d(0) !== 16'h4321) $display("FAIL tog_w0 got %h exp 4321", got_d(0)); else passes++;
    checks++; if (got_d(1) !== 16'h8765) $display("FAIL tog_w1 got %h exp 8765", got_d(1)); else passes++;
    checks++; if (got_c(1) !== 3'd4) $display("FAIL tog_c1 got %0d exp 4", got_c(1)); else passes++;
    checks++; if (ren_while_empty !== 0) $display("FAIL tog_ren_empty got %0d exp 0", ren_while_empty); else passes++;
    checks++; if (pops !== 8) $display("FAIL tog_pops got %0d exp 8", pops); else passes++;
    empty_toggle = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge Clk);
    Out_Ready_in = 1'b0;
    outq_d.delete(); outq_c.delete();
    pops = 0;
    load(1, 8);
    for (int i = 0; i < 30 && pops < 6; i++) tick();
    checks++; if (pops !== 6) $display("FAIL rst_mid_pops got %0d exp 6", pops); else passes++;
    checks++; if (Out_Data_out !== 16'h4321) $display("FAIL rst_mid_pre_dat got %h exp 4321", Out_Data_out); else passes++;
    checks++; if (Busy_out !== 1'b1) $display("FAIL rst_mid_pre_busy got %b exp 1", Busy_out); else passes++;
    #1 Reset_n_in = 1'b0;
    #1;
    checks++; if (Out_Valid_out !== 1'b0) $display("FAIL rst_mid_vld got %b exp 0", Out_Valid_out); else passes++;
    checks++; if (Out_Data_out !== 16'h0) $display("FAIL rst_mid_dat got %h exp 0000", Out_Data_out); else passes++;
    checks++; if (Out_Count_out !== 3'd0) $display("FAIL rst_mid_cnt got %0d exp 0", Out_Count_out); else passes++;
    checks++; if (Busy_out !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", Busy_out); else passes++;
    checks++; if (Fifo_ReadEn_out !== 1'b0) $display("FAIL rst_mid_ren got %b exp 0", Fifo_ReadEn_out); else passes++;
    q.delete();
    tick();
    Out_Ready_in = 1'b1;
    load(1, 4);
    @(negedge Clk);
    Reset_n_in = 1'b1;
    wait_outs(1, 20, ok);
    checks++; if (got_d(0) !== 16'h4321) $display("FAIL rst_after_word got %h exp 4321", got_d(0)); else passes++;
    checks++; if (got_c(0) !== 3'd4) $display("FAIL rst_after_cnt got %0d exp 4", got_c(0)); else passes++;
    wait_idle(ok);
    checks++; if (outq_d.size() !== 1) $display("FAIL rst_after_count got %0d exp 1", outq_d.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_empty_toggle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
